// File: rtl/sprite_line_engine.sv
// Multi-sprite scanline renderer: composites the next row into the back half of a ping-pong
// line buffer while the front half streams out. Optional horizontal flip under SPRITE_FLIP_EN.
module sprite_line_engine #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned SCALE       = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned PIX_W       = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Line_Start,
  input  logic [9:0]       i_Next_Row,
  input  logic [9:0]       i_Rd_Col,
  output logic [PIX_W-1:0] o_Pixel,
  input  logic             i_Attr_We,
  input  logic [3:0]       i_Attr_Idx,
  input  logic             i_Attr_En,
  input  logic [9:0]       i_Attr_X,
  input  logic [9:0]       i_Attr_Y,
  input  logic [5:0]       i_Attr_Num,
`ifdef SPRITE_FLIP_EN
  input  logic             i_Attr_Flip,
`endif
  output logic [5:0]       o_Rom_Sprite,
  output logic [2:0]       o_Rom_Row,
  output logic [2:0]       o_Rom_Col,
  input  logic [PIX_W-1:0] i_Rom_Pixel,
  output logic             o_Busy,
  output logic             o_Overrun
);

  localparam int unsigned SprW   = 8 * SCALE;
  localparam logic [10:0] HActW  = 11'(H_ACTIVE);

  typedef enum logic [2:0] {StIdle, StClear, StScan, StDraw, StDone} state_e;

  logic [PIX_W-1:0] mem [2][H_ACTIVE];

  logic       slot_en_q  [16];
  logic [9:0] slot_x_q   [16];
  logic [9:0] slot_y_q   [16];
  logic [5:0] slot_num_q [16];
`ifdef SPRITE_FLIP_EN
  logic       slot_flip_q [16];
  logic       lat_flip_q;
`endif

  state_e     state_q;
  logic [9:0] row_q;
  logic [9:0] clr_cnt_q;
  logic [9:0] lat_x_q;
  logic [3:0] slot_q;
  logic [5:0] cnt_q;
  logic       bank_q, valid_q, done_q;

  logic [9:0]       dy;
  logic             hit;
  logic [2:0]       trow;
  logic [5:0]       k_next;
  logic [2:0]       col_next;
  logic [2:0]       col_first;
  logic [10:0]      wr_x;
  logic             wr_en;
  logic [9:0]       wr_addr;
  logic [PIX_W-1:0] wr_data;

  always_comb begin
    dy        = row_q - slot_y_q[slot_q];  // mod 1024 so sprites near y=1023 wrap to the top
    hit       = slot_en_q[slot_q] && (dy < 10'(SprW));
    trow      = 3'(dy / 10'(SCALE));
    k_next    = cnt_q + 6'd1;
    col_next  = 3'(k_next / 6'(SCALE));
    col_first = 3'd0;
`ifdef SPRITE_FLIP_EN
    if (lat_flip_q) col_next = 3'd7 - col_next;
    if (slot_flip_q[slot_q]) col_first = 3'd7;
`endif
    // ROM data arriving in DRAW cycle n belongs to pixel k = n-1
    wr_x    = {1'b0, lat_x_q} + 11'(cnt_q) - 11'd1;
    wr_en   = 1'b0;
    wr_addr = clr_cnt_q;
    wr_data = '0;
    if (state_q == StClear) begin
      wr_en = 1'b1;
    end else if (state_q == StDraw && cnt_q != 6'd0 && i_Rom_Pixel != '0 && wr_x < HActW) begin
      wr_en   = 1'b1;
      wr_addr = wr_x[9:0];
      wr_data = i_Rom_Pixel;
    end
  end

  assign o_Busy = (state_q != StIdle);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= StIdle;
      row_q        <= '0;
      clr_cnt_q    <= '0;
      lat_x_q      <= '0;
      slot_q       <= '0;
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Rom_Sprite <= '0;
      o_Rom_Row    <= '0;
      o_Rom_Col    <= '0;
      for (int i = 0; i < 16; i++) begin
        slot_en_q[i]  <= 1'b0;
        slot_x_q[i]   <= '0;
        slot_y_q[i]   <= '0;
        slot_num_q[i] <= '0;
`ifdef SPRITE_FLIP_EN
        slot_flip_q[i] <= 1'b0;
`endif
      end
`ifdef SPRITE_FLIP_EN
      lat_flip_q <= 1'b0;
`endif
    end else begin
      o_Overrun <= 1'b0;
      if (i_Attr_We && 32'(i_Attr_Idx) < NUM_SPRITES) begin
        slot_en_q[i_Attr_Idx]  <= i_Attr_En;
        slot_x_q[i_Attr_Idx]   <= i_Attr_X;
        slot_y_q[i_Attr_Idx]   <= i_Attr_Y;
        slot_num_q[i_Attr_Idx] <= i_Attr_Num;
`ifdef SPRITE_FLIP_EN
        slot_flip_q[i_Attr_Idx] <= i_Attr_Flip;
`endif
      end
      if (i_Line_Start) begin
        if (state_q == StIdle) begin
          if (done_q) bank_q <= ~bank_q;
        end else begin
          o_Overrun <= 1'b1;
        end
        done_q    <= 1'b0;
        row_q     <= i_Next_Row;
        clr_cnt_q <= '0;
        state_q   <= StClear;
      end else begin
        unique case (state_q)
          StIdle: ;
          StClear: begin
            if (clr_cnt_q == 10'(H_ACTIVE - 1)) begin
              state_q <= StScan;
              slot_q  <= 4'(NUM_SPRITES - 1);
            end else begin
              clr_cnt_q <= clr_cnt_q + 10'd1;
            end
          end
          StScan: begin
            if (hit) begin
              lat_x_q      <= slot_x_q[slot_q];
              o_Rom_Sprite <= slot_num_q[slot_q];
              o_Rom_Row    <= trow;
              o_Rom_Col    <= col_first;
`ifdef SPRITE_FLIP_EN
              lat_flip_q   <= slot_flip_q[slot_q];
`endif
              cnt_q        <= '0;
              state_q      <= StDraw;
            end else if (slot_q == 4'd0) begin
              state_q <= StDone;
            end else begin
              slot_q <= slot_q - 4'd1;
            end
          end
          StDraw: begin
            if (cnt_q == 6'(SprW)) begin
              if (slot_q == 4'd0) begin
                state_q <= StDone;
              end else begin
                slot_q  <= slot_q - 4'd1;
                state_q <= StScan;
              end
            end else begin
              cnt_q     <= k_next;
              o_Rom_Col <= col_next;
            end
          end
          StDone: begin
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Line buffer storage is deliberately not reset
  always_ff @(posedge i_Clk) begin
    if (wr_en) mem[~bank_q][wr_addr] <= wr_data;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Pixel <= '0;
    end else if (valid_q && {1'b0, i_Rd_Col} < HActW) begin
      o_Pixel <= mem[bank_q][i_Rd_Col];
    end else begin
      o_Pixel <= '0;
    end
  end

endmodule

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
- Multi-sprite scanline renderer for the VGA sprite demo.
- Holds NUM_SPRITES attribute slots and, during line N, composites all sprites hitting line N+1 into the back half of a ping-pong line buffer.
- Streams the front half to the VGA colour stage.
- Adds over the single-sprite design: per-sprite position/enable, pixel-scaling, transparency, fixed priority, right-edge clipping and overrun detection.
- Sprite texels come from the existing 64x8x8 2-bit sprite ROM, which has 1-cycle read latency.

Parameters:
- NUM_SPRITES, 8, number of attribute slots (1..16).
- SCALE, 2, texel-to-pixel magnification; legal values 1, 2, 4.
- H_ACTIVE, 640, visible pixels per line; this is also the line-buffer depth per bank.
- PIX_W, 2, bits per pixel/colour index.

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Line_Start  in  1  one-cycle pulse at column 0 of every line, including blanking lines.
- i_Next_Row  in  10  row to render into the back bank; sampled on i_Line_Start.
- i_Rd_Col  in  10  display column for the front-bank read.
- o_Pixel  out  PIX_W  front-bank pixel at i_Rd_Col; 1-cycle latency.
- i_Attr_We  in  1  attribute write strobe.
- i_Attr_Idx  in  4  slot index; writes with index >= NUM_SPRITES are ignored.
- i_Attr_En  in  1  slot enable.
- i_Attr_X  in  10  left pixel x.
- i_Attr_Y  in  10  top pixel y.
- i_Attr_Num  in  6  ROM sprite number.
- o_Rom_Sprite  out  6  ROM sprite number.
- o_Rom_Row  out  3  ROM texel row.
- o_Rom_Col  out  3  ROM texel column.
- i_Rom_Pixel  in  PIX_W  ROM data; valid one cycle after the address.
- o_Busy  out  1  high while rendering is in progress (FSM not IDLE).
- o_Overrun  out  1  one-cycle pulse when a line start aborts an unfinished render.

Behaviour:
- Reset values:
  - o_Pixel=0, o_Busy=0, o_Overrun=0.
  - Bank select=0.
  - All slots: En=0, X=0, Y=0, Num=0.
  - FSM in IDLE; valid flag=0.
  - ROM address outputs=0.
- Reset mid-render returns all of the above immediately. Buffer contents are not reset.
- Read path:
  - o_Pixel is registered from the front bank at i_Rd_Col.
  - o_Pixel=0 if i_Rd_Col >= H_ACTIVE.
  - o_Pixel=0 while the valid flag is 0. The valid flag sets on the first completed render.
- On i_Line_Start:
  - Toggle the bank select only if the previous render completed.
  - Latch i_Next_Row.
  - Go to CLEAR.
- FSM states:
  - IDLE: wait for i_Line_Start.
  - CLEAR: write 0 to back-bank addresses 0..H_ACTIVE-1, one per cycle (H_ACTIVE cycles).
  - SCAN:
    - Visits slot NUM_SPRITES-1 down to 0, one cycle per slot.
    - A slot hits when En=1 and dy=(row-Y) mod 1024 < 8*SCALE.
    - A hit latches the slot attributes and goes to DRAW; a miss moves to the next slot.
    - After slot 0, go to DONE.
  - DRAW:
    - For k=0..8*SCALE-1, issue ROM address (Num, dy/SCALE, k/SCALE).
    - One cycle later, write i_Rom_Pixel to x=X+k if i_Rom_Pixel != 0 and x < H_ACTIVE, using 11-bit compare with no wrap.
    - Pixel value 0 is transparent and is never written.
    - DRAW lasts 8*SCALE+1 cycles, then returns to SCAN at the next lower slot.
  - DONE: set valid, go to IDLE.
- Priority: lower slot index is drawn later and therefore wins on overlap.
- Cycle budget with defaults: 640 + 8 + 8*17 + 1 = 785 < 800.
- Overrun:
  - If i_Line_Start arrives in a state other than IDLE, pulse o_Overrun for one cycle.
  - Do not toggle the bank; the partial back bank is discarded.
  - Restart CLEAR for the new row.
- Attribute writes:
  - Take effect the next cycle.
  - A slot already latched in DRAW is unaffected.
  - A write to a slot not yet scanned is used by this render.
- Write and read never target the same bank. A simultaneous i_Line_Start and read uses the pre-toggle bank for that cycle.

Optional Feature:
- Macro: SPRITE_FLIP_EN.
- Defined:
  - Adds input i_Attr_Flip (1 bit) and a per-slot Flip bit, reset 0.
  - When Flip=1, ROM column = 7-(k/SCALE), mirroring the sprite horizontally.
- Undefined: the port and the bit are absent; column = k/SCALE.

Test Plan:
- Reset, then a line start with no slots enabled, then read cols 0..639 -> o_Pixel all 0. o_Busy high for 648+1 cycles.
- Slot 0 set to En=1, X=100, Y=50, Num=3, where ROM sprite 3 is all 2s; render row 51 -> cols 100..115 read 2, cols 99 and 116 read 0.
- Slot 1 at X=108 and slot 0 at X=100, both opaque, different colours -> cols 108..115 show slot 0's colour.
- Sprite containing texel value 0 over another sprite -> the underlying pixel is visible at the transparent texels.
- X=630 -> cols 630..639 drawn, no write beyond 639, no wrap to col 0. Y=1020, row 2 -> hit with dy=6.
- Pulse i_Line_Start during CLEAR -> o_Overrun=1 for one cycle, bank unchanged. With SPRITE_FLIP_EN and Flip=1, texel column 0 appears at pixels X+14..X+15.
